pipe_mem_stage: RTL
===================

# pipe_mem_stage

Parametrised MEM stage for the dynamic pipeline CPU. It performs sized, byte-enabled data-memory loads and stores with sign or zero extension and misalignment detection. It inserts a configurable number of memory wait states, stalling upstream stages meanwhile. It registers the MEM/WB pipeline boundary. It sits between the EX/MEM register and write-back and replaces the fixed-word, unregistered MEM stage.

## Interface
- DW, 32: datapath width; must be 32.
- DEPTH, 1024: data memory depth in words; power of two.
- WAIT_STATES, 0: extra cycles per memory access, 0..15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- e_valid  in  1  EX/MEM holds a real instruction.
- e_alu  in  DW  effective address or ALU result.
- e_b  in  DW  store data, right-aligned.
- e_w_dm  in  1  store.
- e_r_dm  in  1  load.
- e_size  in  2  access size: 0=byte, 1=half, 2=word, 3=reserved (treated as word).
- e_sign  in  1  sign-extend loads.
- e_w_rf, e_rn[4:0], e_rfsource[2:0], e_pc4[DW]  in  write-back controls and pc+4, passed through.
- m_stall  out  1  hold upstream, combinational.
- w_valid  out  1  registered instruction valid.
- w_alu, w_dm, w_pc4  out  DW  registered ALU result, extended load data, pc+4.
- w_w_rf, w_rn, w_rfsource  out  1/5/3  registered write-back controls.
- w_misalign  out  1  registered misaligned-access flag.
- w_badaddr  out  DW  address of the faulting access.

## Operation
- Memory op = e_valid & (e_w_dm | e_r_dm). If both are set, it is a store; the load is ignored.
- Word index = e_alu[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned: half with e_alu[0]=1, or word with e_alu[1:0]≠0.
  - No memory write.
  - w_w_rf forced 0.
  - w_misalign=1 and w_badaddr=e_alu.
  - No wait states are consumed.
- Store byte enables:
  - Byte: lane e_alu[1:0] gets e_b[7:0].
  - Half: lanes {e_alu[1],0}/+1 get e_b[15:0].
  - Word: all lanes get e_b.
- Load: the lane is selected the same way and the result is right-aligned. Upper bits are filled with the sign bit if e_sign, else zeros. Non-load ops give w_dm=0.
- FSM states: IDLE and WAIT; 4-bit counter cnt.
  - IDLE: an aligned memory op with WAIT_STATES>0 goes to WAIT with cnt=1. All other cases complete this cycle.
  - WAIT: when cnt==WAIT_STATES, complete and return to IDLE; else cnt+1.
- Completion:
  - The store write happens exactly once, at the completing edge.
  - The load sample is taken from the array as seen at that edge.
  - All w_* registers are loaded from the e_* inputs.
- m_stall = aligned memory op & ((state==IDLE & WAIT_STATES>0) | (state==WAIT & cnt≠WAIT_STATES)).
- While stalled, w_valid=0 (bubble) and the other w_* outputs hold.
- e_valid=0 completes as a bubble: w_valid=0, w_w_rf=0, w_misalign=0, and no memory access.
- Upstream keeps e_* stable while m_stall=1. Changes made during a stall are undefined.
- Memory contents are not reset.

## Timing
- Reset values: all w_* = 0, state=IDLE, cnt=0, m_stall=0.
- Latency:
  - Non-memory or misaligned op: 1 cycle, input to registered output.
  - Aligned memory op: 1+WAIT_STATES cycles; m_stall is high for exactly WAIT_STATES cycles.
- Back-to-back memory ops: the second op enters IDLE on the cycle after the first completes, with no extra dead cycle.
- Reset during WAIT:
  - Returns to IDLE.
  - The pending store is discarded.
  - m_stall drops in the same cycle rst is sampled.
- Store followed by a load to the same word in consecutive instructions: the load returns the new data.

## Structure
- Package pipe_mem_pkg holds:
  - SIZE_BYTE/HALF/WORD encodings.
  - FSM state encoding.
  - Byte-enable and load-extend functions.
- Sub-module pipe_dmem_be: word array with 4 byte write enables and asynchronous read.
- pipe_mem_stage holds the FSM, counter, alignment logic and MEM/WB registers.

## Test plan
- WAIT_STATES=0: store word 0xDEADBEEF to 0x10, then load byte signed from 0x13 → w_dm=0xFFFFFFDE; load half unsigned from 0x10 → 0x0000BEEF.
- Store byte 0x7F to 0x11 over the word above, then load word 0x10 → 0xDEAD7FEF.
- WAIT_STATES=3: a load asserts m_stall for 3 cycles, w_valid rises on cycle 4, and w_valid=0 during the stall.
- Load half from 0x21 → w_misalign=1, w_badaddr=0x21, w_w_rf=0, no stall, and memory unchanged.
- Address wrap with DEPTH=1024: a store to 0x1004 is read back from 0x0004.
- WAIT_STATES=3, store pending, rst at cycle 2 → m_stall=0 that cycle, all w_*=0, and a later load of that address returns the old value.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared encodings and lane helpers for the MEM stage: access sizes, FSM states,
// store byte enables / lane replication and load extraction with extension.
package pipe_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << addr;
            SIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data into every lane; byte enables pick the live one.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: store_lanes = {4{data[7:0]}};
            SIZE_HALF: store_lanes = {2{data[15:0]}};
            default:   store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] addr,
                                                input logic sign, input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = word[{addr[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: load_extend = {{24{sign & lane_b[7]}}, lane_b};
            SIZE_HALF: load_extend = {{16{sign & lane_h[15]}}, lane_h};
            default:   load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/pipe_dmem_be.sv
// Data memory word array: four byte write enables on the clock edge, asynchronous read.
module pipe_dmem_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: sized/byte-enabled loads and stores, misalignment trapping, optional
// wait states that stall upstream, and the registered MEM/WB boundary.
module pipe_mem_stage
    import pipe_mem_pkg::*;
#(
    parameter int DW          = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          e_valid,
    input  logic [DW-1:0] e_alu,
    input  logic [DW-1:0] e_b,
    input  logic          e_w_dm,
    input  logic          e_r_dm,
    input  logic [1:0]    e_size,
    input  logic          e_sign,
    input  logic          e_w_rf,
    input  logic [4:0]    e_rn,
    input  logic [2:0]    e_rfsource,
    input  logic [DW-1:0] e_pc4,
    output logic          m_stall,
    output logic          w_valid,
    output logic [DW-1:0] w_alu,
    output logic [DW-1:0] w_dm,
    output logic [DW-1:0] w_pc4,
    output logic          w_w_rf,
    output logic [4:0]    w_rn,
    output logic [2:0]    w_rfsource,
    output logic          w_misalign,
    output logic [DW-1:0] w_badaddr
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic       HAS_WAIT = (WAIT_STATES > 0);

    mem_state_t r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;

    logic          w_mem_op, w_addr_bad, w_misalign_op, w_aligned_op;
    logic          w_stall, w_complete, w_is_load;
    logic [3:0]    w_we;
    logic [31:0]   w_rdata, w_load_data;

    logic          r_valid, r_w_rf, r_misalign;
    logic [DW-1:0] r_alu, r_dm, r_pc4, r_badaddr;
    logic [4:0]    r_rn;
    logic [2:0]    r_rfsource;

    assign w_mem_op      = e_valid & (e_w_dm | e_r_dm);
    assign w_addr_bad    = (e_size == SIZE_HALF) ? e_alu[0] :
                           (e_size == SIZE_BYTE) ? 1'b0 : (e_alu[1:0] != 2'b00);
    assign w_misalign_op = w_mem_op & w_addr_bad;
    assign w_aligned_op  = w_mem_op & ~w_addr_bad;
    assign w_is_load     = e_valid & e_r_dm & ~e_w_dm & ~w_addr_bad;

    // Reset wins combinationally so upstream is released in the cycle rst is sampled.
    assign w_stall    = ~rst & w_aligned_op &
                        (((r_state == ST_IDLE) & HAS_WAIT) | ((r_state == ST_WAIT) & (r_cnt != WS)));
    assign w_complete = ~w_stall;
    assign m_stall    = w_stall;

    assign w_we = (~rst & w_complete & w_aligned_op & e_w_dm) ? byte_en(e_size, e_alu[1:0]) : 4'b0000;

    pipe_dmem_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (e_alu[AW+1:2]),
        .i_wdata (store_lanes(e_size, e_b)),
        .o_rdata (w_rdata)
    );

    assign w_load_data = w_is_load ? load_extend(e_size, e_alu[1:0], e_sign, w_rdata) : '0;

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        if (w_stall) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = (r_state == ST_IDLE) ? 4'd1 : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_alu      <= '0;
            r_dm       <= '0;
            r_pc4      <= '0;
            r_w_rf     <= 1'b0;
            r_rn       <= '0;
            r_rfsource <= '0;
            r_misalign <= 1'b0;
            r_badaddr  <= '0;
        end else if (w_complete) begin
            r_valid    <= e_valid;
            r_alu      <= e_alu;
            r_dm       <= w_load_data;
            r_pc4      <= e_pc4;
            r_w_rf     <= e_valid & e_w_rf & ~w_misalign_op;
            r_rn       <= e_rn;
            r_rfsource <= e_rfsource;
            r_misalign <= w_misalign_op;
            r_badaddr  <= w_misalign_op ? e_alu : '0;
        end else begin
            // Bubble into WB while waiting; the payload registers keep their last value.
            r_valid    <= 1'b0;
        end
    end

    assign w_valid    = r_valid;
    assign w_alu      = r_alu;
    assign w_dm       = r_dm;
    assign w_pc4      = r_pc4;
    assign w_w_rf     = r_w_rf;
    assign w_rn       = r_rn;
    assign w_rfsource = r_rfsource;
    assign w_misalign = r_misalign;
    assign w_badaddr  = r_badaddr;

endmodule
